// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants for the register file writeback controller
package regfile_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 2;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// rtl/regfile_wb_arbiter_scoreboard.sv - per-register pending-write counters with RAW busy query
module regfile_wb_arbiter_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_reg,
  output logic              alloc_ready,
  input  logic              retire_valid,
  input  logic [ADDR_W-1:0] retire_reg,
  input  logic [ADDR_W-1:0] rs_query,
  input  logic [ADDR_W-1:0] rt_query,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              err_underflow
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic alloc_zero, retire_zero, same_reg, alloc_inc, retire_dec;

  assign alloc_zero  = (alloc_reg == ADDR_W'(REG_ZERO));
  assign retire_zero = (retire_reg == ADDR_W'(REG_ZERO));
  assign same_reg    = retire_valid && (retire_reg == alloc_reg);

  // A full counter can still accept an alloc when a retire to the same register frees a slot.
  assign alloc_ready = alloc_zero || (cnt[alloc_reg] != CNT_MAX) || same_reg;
  assign alloc_inc   = alloc_valid && alloc_ready && !alloc_zero;
  assign retire_dec  = retire_valid && !retire_zero;

  assign rs_busy = (cnt[rs_query] != '0);
  assign rt_busy = (cnt[rt_query] != '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (alloc_inc && (alloc_reg == ADDR_W'(r)) && !(retire_dec && (retire_reg == ADDR_W'(r))))
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (retire_dec && (retire_reg == ADDR_W'(r)) && !(alloc_inc && (alloc_reg == ADDR_W'(r)))
                 && (cnt[r] != '0))
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
      if (retire_dec && (cnt[retire_reg] == '0))
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates ALU and load writebacks onto the register file write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_reg,
  output logic              alloc_ready,
  input  logic [ADDR_W-1:0] rs_query,
  input  logic [ADDR_W-1:0] rt_query,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWre,
  output logic              err_underflow
);

  req_id_t           last_grant;
  logic              wb_fire;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;

  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (alu_valid && mem_valid) begin
      if (FIXED_PRIO != 0)            mem_ready = 1'b1;
      else if (last_grant == REQ_MEM) alu_ready = 1'b1;
      else                            mem_ready = 1'b1;
    end else begin
      alu_ready = alu_valid;
      mem_ready = mem_valid;
    end
  end

  // At most one requester is ready, so the winner's fields can be muxed on mem_ready alone.
  assign wb_fire = (alu_valid && alu_ready) || (mem_valid && mem_ready);
  assign wb_reg  = mem_ready ? mem_reg  : alu_reg;
  assign wb_data = mem_ready ? mem_data : alu_data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WriteReg   <= '0;
      WriteData  <= '0;
      RegWre     <= 1'b0;
      last_grant <= REQ_MEM;
    end else begin
      RegWre <= wb_fire && (wb_reg != ADDR_W'(REG_ZERO));
      if (wb_fire) begin
        WriteReg   <= wb_reg;
        WriteData  <= wb_data;
        last_grant <= mem_ready ? REQ_MEM : REQ_ALU;
      end
    end
  end

  regfile_wb_arbiter_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .CLK           (CLK),
    .RST           (RST),
    .alloc_valid   (alloc_valid),
    .alloc_reg     (alloc_reg),
    .alloc_ready   (alloc_ready),
    .retire_valid  (wb_fire),
    .retire_reg    (wb_reg),
    .rs_query      (rs_query),
    .rt_query      (rt_query),
    .rs_busy       (rs_busy),
    .rt_busy       (rt_busy),
    .err_underflow (err_underflow)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        alu_valid, mem_valid, alloc_valid;
  logic [4:0]  alu_reg, mem_reg, alloc_reg, rs_query, rt_query;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, alloc_ready, rs_busy, rt_busy;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWre, err_underflow;

  int checks = 0;
  int fails  = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(2), .FIXED_PRIO(0)) dut (
    .CLK(CLK), .RST(RST),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg), .alloc_ready(alloc_ready),
    .rs_query(rs_query), .rt_query(rt_query), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWre(RegWre), .err_underflow(err_underflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic alloc(input logic [4:0] r);
    alloc_valid = 1'b1;
    alloc_reg   = r;
    tick();
    alloc_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b0;
    alu_valid = 0; mem_valid = 0; alloc_valid = 0;
    alu_reg = 0; mem_reg = 0; alloc_reg = 0; rs_query = 0; rt_query = 0;
    alu_data = 0; mem_data = 0;
    #12;
    check("rst_regwre", RegWre, 0);
    check("rst_wreg", WriteReg, 0);
    check("rst_wdata", WriteData, 0);
    check("rst_err", err_underflow, 0);
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // Round-robin tie: r3 twice, r4 once pending
    alloc(5'd3); alloc(5'd3); alloc(5'd4);
    alu_valid = 1; alu_reg = 5'd3; alu_data = 32'hA;
    mem_valid = 1; mem_reg = 5'd4; mem_data = 32'hB;
    #1;
    check("tie1_alu_ready", alu_ready, 1);
    check("tie1_mem_ready", mem_ready, 0);
    tick();
    check("tie1_regwre", RegWre, 1);
    check("tie1_wreg", WriteReg, 3);
    check("tie1_wdata", WriteData, 32'hA);
    check("tie2_mem_ready", mem_ready, 1);
    check("tie2_alu_ready", alu_ready, 0);
    tick();
    check("tie2_wreg", WriteReg, 4);
    check("tie2_wdata", WriteData, 32'hB);
    check("tie3_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0; mem_valid = 0;
    check("tie3_regwre", RegWre, 1);
    check("tie3_wreg", WriteReg, 3);
    check("tie3_wdata", WriteData, 32'hA);
    rs_query = 5'd3; rt_query = 5'd4;
    tick();
    check("tie_idle_regwre", RegWre, 0);
    check("tie_r3_free", rs_busy, 0);
    check("tie_r4_free", rt_busy, 0);
    check("tie_no_err", err_underflow, 0);

    // Single ALU write to r5
    alloc(5'd5);
    alu_valid = 1; alu_reg = 5'd5; alu_data = 32'h1234;
    #1;
    check("alu_ready", alu_ready, 1);
    check("alu_mem_ready", mem_ready, 0);
    tick();
    alu_valid = 0;
    check("alu_regwre", RegWre, 1);
    check("alu_wreg", WriteReg, 5);
    check("alu_wdata", WriteData, 32'h1234);
    tick();
    check("alu_regwre_drop", RegWre, 0);

    // Scoreboard counting on r7
    rs_query = 5'd7;
    alloc(5'd7); alloc(5'd7);
    check("sb_busy2", rs_busy, 1);
    mem_valid = 1; mem_reg = 5'd7; mem_data = 32'h77;
    #1;
    check("sb_busy_same_cycle", rs_busy, 1);
    tick();
    check("sb_busy1", rs_busy, 1);
    tick();
    mem_valid = 0;
    check("sb_busy0", rs_busy, 0);
    alloc(5'd7); alloc(5'd7); alloc(5'd7);
    alloc_valid = 1; alloc_reg = 5'd7;
    #1;
    check("sb_full_ready", alloc_ready, 0);
    tick();
    alloc_valid = 0;

    // Same-cycle alloc and retire on r9
    rt_query = 5'd9;
    alloc(5'd9);
    alloc_valid = 1; alloc_reg = 5'd9;
    mem_valid = 1; mem_reg = 5'd9; mem_data = 32'h99;
    #1;
    check("same_alloc_ready", alloc_ready, 1);
    check("same_mem_ready", mem_ready, 1);
    tick();
    alloc_valid = 0;
    check("same_busy", rt_busy, 1);
    tick();
    mem_valid = 0;
    check("same_cnt_was1", rt_busy, 0);
    check("same_no_err", err_underflow, 0);

    // r0 writes and allocs are inert
    rs_query = 5'd0;
    alloc_valid = 1; alloc_reg = 5'd0;
    alu_valid = 1; alu_reg = 5'd0; alu_data = 32'hFFFF;
    #1;
    check("r0_alloc_ready", alloc_ready, 1);
    check("r0_alu_ready", alu_ready, 1);
    tick();
    alloc_valid = 0; alu_valid = 0;
    check("r0_regwre", RegWre, 0);
    check("r0_busy", rs_busy, 0);

    // Underflow on r12
    mem_valid = 1; mem_reg = 5'd12; mem_data = 32'hC0DE;
    tick();
    mem_valid = 0;
    check("uf_regwre", RegWre, 1);
    check("uf_wreg", WriteReg, 12);
    check("uf_err", err_underflow, 1);
    tick(); tick();
    check("uf_sticky", err_underflow, 1);

    // Async reset while a write is in flight; r7 still has 3 pending
    rs_query = 5'd7;
    check("pre_rst_busy", rs_busy, 1);
    alu_valid = 1; alu_reg = 5'd7; alu_data = 32'h55;
    tick();
    alu_valid = 0;
    check("pre_rst_regwre", RegWre, 1);
    RST = 1'b0;
    #1;
    check("arst_regwre", RegWre, 0);
    check("arst_wreg", WriteReg, 0);
    check("arst_wdata", WriteData, 0);
    check("arst_err", err_underflow, 0);
    check("arst_busy", rs_busy, 0);
    @(negedge CLK);
    RST = 1'b1;
    alu_valid = 1; alu_reg = 5'd1; mem_valid = 1; mem_reg = 5'd2;
    #1;
    check("arst_tie_alu", alu_ready, 1);
    check("arst_tie_mem", mem_ready, 0);
    alu_valid = 0; mem_valid = 0;
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
